// File: rtl/debug_instruction_injector.sv
// Turns abstract register-access commands into CSRRW/CSRRS/EBREAK sequences
// for a halted hart; data moves through DATA_CSR and x8 is preserved in SAVE_CSR.
module debug_instruction_injector #(
    parameter logic [11:0] DATA_CSR    = 12'h7B2,
    parameter logic [11:0] SAVE_CSR    = 12'h7B3,
    parameter logic [4:0]  SCRATCH_GPR = 5'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_regno,
    input  logic        cmd_write,
    output logic        cmd_done,
    output logic [1:0]  cmd_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    input  logic        instr_exception
);
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [11:0] regno_q, regno_d;
    logic        write_q, write_d;
    logic        csr_q, csr_d;
    logic        sticky_q, sticky_d;
    logic [1:0]  code_q, code_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cmd_done_q, cmd_done_d;
    logic [1:0]  cmd_err_q, cmd_err_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;

    logic        handshake;
    logic [2:0]  restore_step, last_step, base_step;

    function automatic logic [31:0] csrrw_f(logic [11:0] csr, logic [4:0] rs1, logic [4:0] rd);
        return {csr, rs1, 3'b001, rd, 7'b1110011};
    endfunction

    function automatic logic [31:0] csrrs_f(logic [11:0] csr, logic [4:0] rs1, logic [4:0] rd);
        return {csr, rs1, 3'b010, rd, 7'b1110011};
    endfunction

    function automatic logic [31:0] word_f(logic is_csr, logic wr, logic [2:0] step, logic [11:0] c);
        logic [31:0] w;
        w = EBREAK;
        if (!is_csr) begin
            if (step == 3'd0)
                w = wr ? csrrs_f(DATA_CSR, 5'd0, c[4:0]) : csrrw_f(DATA_CSR, c[4:0], 5'd0);
        end else begin
            case (step)
                3'd0: w = csrrw_f(SAVE_CSR, SCRATCH_GPR, 5'd0);
                3'd1: w = wr ? csrrs_f(DATA_CSR, 5'd0, SCRATCH_GPR) : csrrs_f(c, 5'd0, SCRATCH_GPR);
                3'd2: w = wr ? csrrw_f(c, SCRATCH_GPR, 5'd0) : csrrw_f(DATA_CSR, SCRATCH_GPR, 5'd0);
                3'd3: w = csrrs_f(SAVE_CSR, 5'd0, SCRATCH_GPR);
                default: w = EBREAK;
            endcase
        end
        return w;
    endfunction

    assign handshake    = instr_valid_q & instr_ready;
    assign restore_step = csr_q ? 3'd3 : 3'd1;
    assign last_step    = csr_q ? 3'd4 : 3'd1;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        regno_d   = regno_q;
        write_d   = write_q;
        csr_d     = csr_q;
        sticky_d  = sticky_q;
        code_d    = code_q;
        base_step = handshake ? 3'(step_q + 3'd1) : step_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    regno_d  = cmd_regno[11:0];
                    write_d  = cmd_write;
                    step_d   = 3'd0;
                    sticky_d = 1'b0;
                    code_d   = 2'b00;
                    if (cmd_regno[15:12] == 4'h0) begin
                        csr_d   = 1'b1;
                        state_d = S_EMIT;
                    end else if (cmd_regno[15:5] == 11'h080) begin
                        csr_d   = 1'b0;
                        state_d = S_EMIT;
                    end else begin
                        csr_d   = 1'b0;
                        code_d  = 2'b10;
                        state_d = S_DONE;
                    end
                end
            end
            S_EMIT: begin
                // A faulting access skips straight to the x8 restore (or EBREAK for GPRs).
                if (instr_exception) begin
                    sticky_d = 1'b1;
                    if (base_step < restore_step)
                        base_step = restore_step;
                end
                if (handshake && step_q == last_step)
                    state_d = S_DONE;
                else
                    step_d = base_step;
            end
            S_DONE: begin
                state_d  = S_IDLE;
                step_d   = 3'd0;
                sticky_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d   = (state_d == S_IDLE);
        cmd_done_d    = (state_d == S_DONE);
        cmd_err_d     = (state_d == S_DONE) ? (sticky_d ? 2'b11 : code_d) : 2'b00;
        instr_valid_d = (state_d == S_EMIT);
        instr_d       = instr_valid_d ? word_f(csr_d, write_d, step_d, regno_d) : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            step_q        <= 3'd0;
            regno_q       <= 12'd0;
            write_q       <= 1'b0;
            csr_q         <= 1'b0;
            sticky_q      <= 1'b0;
            code_q        <= 2'b00;
            cmd_ready_q   <= 1'b1;
            cmd_done_q    <= 1'b0;
            cmd_err_q     <= 2'b00;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            regno_q       <= regno_d;
            write_q       <= write_d;
            csr_q         <= csr_d;
            sticky_q      <= sticky_d;
            code_q        <= code_d;
            cmd_ready_q   <= cmd_ready_d;
            cmd_done_q    <= cmd_done_d;
            cmd_err_q     <= cmd_err_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign cmd_done    = cmd_done_q;
    assign cmd_err     = cmd_err_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
endmodule

// File: tb/tb_debug_instruction_injector.sv
// Directed bench for debug_instruction_injector: instruction sequences, stalls,
// exceptions, unsupported regno and mid-sequence reset.
module tb_debug_instruction_injector;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_regno;
    logic        cmd_write;
    logic        cmd_done;
    logic [1:0]  cmd_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_exception;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    debug_instruction_injector dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_regno(cmd_regno), .cmd_write(cmd_write),
        .cmd_done(cmd_done), .cmd_err(cmd_err),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_exception(instr_exception)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] regno, input logic wr);
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_regno = regno;
        cmd_write = wr;
        tick();
        cmd_valid = 1'b0;
        $display("cmd regno=%h write=%0d accepted", regno, wr);
    endtask

    // Offer one word: hold for 'stalls' cycles with instr_ready low, then hand it off.
    task automatic expect_word(input logic [31:0] w, input int stalls, input logic exc);
        for (int i = 0; i < stalls; i++) begin
            instr_ready = 1'b0;
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, w);
            chk("stall_busy", 32'(cmd_ready), 32'd0);
            tick();
        end
        instr_ready     = 1'b1;
        instr_exception = exc;
        chk("word_valid", 32'(instr_valid), 32'd1);
        chk("word_instr", instr, w);
        $display("word %h handed off (stalls=%0d exc=%0d)", instr, stalls, exc);
        tick();
        instr_exception = 1'b0;
    endtask

    task automatic expect_done(input logic [1:0] err);
        chk("done_pulse", 32'(cmd_done), 32'd1);
        chk("done_err", 32'(cmd_err), 32'(err));
        chk("done_no_valid", 32'(instr_valid), 32'd0);
        chk("done_busy", 32'(cmd_ready), 32'd0);
        $display("cmd_done err=%b", cmd_err);
        tick();
        chk("done_cleared", 32'(cmd_done), 32'd0);
        chk("ready_after_done", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_regno = 16'h0; cmd_write = 1'b0;
        instr_ready = 1'b1; instr_exception = 1'b0;
        tick();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(cmd_done), 32'd0);
        chk("rst_err", 32'(cmd_err), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        rst = 1'b0;
        tick();

        // GPR read x5
        issue(16'h1005, 1'b0);
        expect_word(32'h7B22_9073, 0, 1'b0);
        expect_word(EBREAK, 0, 1'b0);
        expect_done(2'b00);

        // GPR write x5 with ready toggling
        issue(16'h1005, 1'b1);
        expect_word(32'h7B20_22F3, 1, 1'b0);
        expect_word(EBREAK, 1, 1'b0);
        expect_done(2'b00);

        // CSR read 0x300
        issue(16'h0300, 1'b0);
        expect_word(32'h7B34_1073, 0, 1'b0);
        expect_word(32'h3000_2473, 0, 1'b0);
        expect_word(32'h7B24_1073, 0, 1'b0);
        expect_word(32'h7B30_2473, 0, 1'b0);
        expect_word(EBREAK, 0, 1'b0);
        expect_done(2'b00);

        // CSR write 0x300, exception raised by the CSR write word itself
        issue(16'h0300, 1'b1);
        expect_word(32'h7B34_1073, 0, 1'b0);
        expect_word(32'h7B20_2473, 0, 1'b0);
        expect_word(32'h3004_1073, 0, 1'b1);
        expect_word(32'h7B30_2473, 0, 1'b0);
        expect_word(EBREAK, 0, 1'b0);
        expect_done(2'b11);

        // CSR read with exception on a stalled step 1: jump straight to restore
        issue(16'h0300, 1'b0);
        expect_word(32'h7B34_1073, 0, 1'b0);
        instr_ready = 1'b0;
        instr_exception = 1'b1;
        chk("exc_offered", instr, 32'h3000_2473);
        tick();
        instr_exception = 1'b0;
        expect_word(32'h7B30_2473, 0, 1'b0);
        expect_word(EBREAK, 0, 1'b0);
        expect_done(2'b11);

        // Unsupported regno, then immediate accept of a write to x0
        issue(16'h2000, 1'b0);
        expect_done(2'b10);
        issue(16'h1000, 1'b1);
        expect_word(32'h7B20_2073, 0, 1'b0);
        expect_word(EBREAK, 0, 1'b0);
        expect_done(2'b00);

        // Reset in the middle of a CSR read
        issue(16'h0300, 1'b0);
        expect_word(32'h7B34_1073, 0, 1'b0);
        expect_word(32'h3000_2473, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_done", 32'(cmd_done), 32'd0);
        chk("midrst_instr", instr, 32'd0);
        $display("reset asserted mid-sequence");
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_no_done", 32'(cmd_done), 32'd0);
        chk("post_rst_idle", 32'(instr_valid), 32'd0);
        issue(16'h1005, 1'b0);
        expect_word(32'h7B22_9073, 0, 1'b0);
        expect_word(EBREAK, 0, 1'b0);
        expect_done(2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
